// File: rtl/mem_store_checker.sv
// mem_store_checker
//   Self-check block for processor benches. Watches the data-memory write
//   bus and compares stores against a loadable table of expected
//   (address, data) pairs. Supports a scratch-address filter, strict
//   ordered or subsequence matching, and a cycle timeout. Results are
//   sticky pass/fail/timeout flags plus capture of the offending store.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   exp_we/idx/adr/data table write (IDLE only)
//   exp_count           valid entries, latched (saturated to DEPTH) on start
//   start               begin a check from IDLE, PASS or FAIL
//   ign_en, ign_adr     ignore stores to ign_adr
//   memwrite, dataadr,
//   writedata           processor data-memory write bus
//   busy                state is RUN
//   pass, fail, timeout sticky result flags
//   match_cnt           entries matched so far
//   err_adr, err_data   offending store (0 on timeout)
module mem_store_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1000,
    parameter int MODE    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_idx,
    input  logic [WIDTH-1:0]           exp_adr,
    input  logic [WIDTH-1:0]           exp_data,
    input  logic [$clog2(DEPTH):0]     exp_count,
    input  logic                       start,
    input  logic                       ign_en,
    input  logic [WIDTH-1:0]           ign_adr,
    input  logic                       memwrite,
    input  logic [WIDTH-1:0]           dataadr,
    input  logic [WIDTH-1:0]           writedata,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [$clog2(DEPTH):0]     match_cnt,
    output logic [WIDTH-1:0]           err_adr,
    output logic [WIDTH-1:0]           err_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    // +1 keeps the counter at least one bit wide when TIMEOUT == 1
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_tab_adr  [DEPTH];
    logic [WIDTH-1:0] r_tab_data [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_match;
    logic [TW-1:0]    r_cyc;
    logic             r_timeout;
    logic [WIDTH-1:0] r_err_adr;
    logic [WIDTH-1:0] r_err_data;

    logic [CW-1:0]    w_cnt_sat;
    logic [CW-1:0]    w_match_nx;
    logic             w_eval;
    logic             w_hit;
    logic             w_to;

    assign w_cnt_sat  = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
    assign w_match_nx = r_match + 1'b1;
    // A store is evaluated unless it targets the scratch address. With X on
    // the bus these equalities go X and the if-chains below treat them as false,
    // so an unknown store is never counted as a hit.
    assign w_eval     = memwrite && !(ign_en && (dataadr == ign_adr));
    // r_match < r_count <= DEPTH while in RUN, so the low bits index safely
    assign w_hit      = (dataadr   == r_tab_adr[r_match[IW-1:0]]) &&
                        (writedata == r_tab_data[r_match[IW-1:0]]);
    assign w_to       = (r_cyc == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_match    <= '0;
            r_cyc      <= '0;
            r_timeout  <= 1'b0;
            r_err_adr  <= '0;
            r_err_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_adr[i]  <= '0;
                r_tab_data[i] <= '0;
            end
        end else begin
            if (exp_we && r_state == S_IDLE) begin
                r_tab_adr[exp_idx]  <= exp_adr;
                r_tab_data[exp_idx] <= exp_data;
            end

            if (start && r_state != S_RUN) begin
                // (re)start: table is kept, everything else is cleared
                r_count    <= w_cnt_sat;
                r_match    <= '0;
                r_cyc      <= '0;
                r_timeout  <= 1'b0;
                r_err_adr  <= '0;
                r_err_data <= '0;
                r_state    <= (w_cnt_sat == '0) ? S_PASS : S_RUN;
            end else if (r_state == S_RUN) begin
                r_cyc <= r_cyc + 1'b1;
                if (w_eval && w_hit) begin
                    r_match <= w_match_nx;
                    // final match beats a coincident timeout
                    if (w_match_nx == r_count) begin
                        r_state <= S_PASS;
                    end else if (w_to) begin
                        r_state   <= S_FAIL;
                        r_timeout <= 1'b1;
                    end
                end else if (w_eval && MODE == 0) begin
                    // mismatch beats a coincident timeout
                    r_state    <= S_FAIL;
                    r_err_adr  <= dataadr;
                    r_err_data <= writedata;
                end else if (w_to) begin
                    r_state    <= S_FAIL;
                    r_timeout  <= 1'b1;
                    r_err_adr  <= '0;
                    r_err_data <= '0;
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign pass      = (r_state == S_PASS);
    assign fail      = (r_state == S_FAIL);
    assign timeout   = r_timeout;
    assign match_cnt = r_match;
    assign err_adr   = r_err_adr;
    assign err_data  = r_err_data;

endmodule

// File: tb/tb_mem_store_checker.sv
// Bench for mem_store_checker: one ordered (MODE=0) and one subsequence
// (MODE=1) instance share the table/bus inputs and have separate starts.
// Expected outputs are queued as each stimulus cycle is driven and are
// popped and compared once the clock edge has produced the DUT response.
module tb_mem_store_checker;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          exp_we;
    logic [IW-1:0] exp_idx;
    logic [W-1:0]  exp_adr, exp_data;
    logic [CW-1:0] exp_count;
    logic          start0, start1;
    logic          ign_en;
    logic [W-1:0]  ign_adr;
    logic          memwrite;
    logic [W-1:0]  dataadr, writedata;

    logic          busy0, pass0, fail0, to0;
    logic [CW-1:0] mc0;
    logic [W-1:0]  ea0, ed0;
    logic          busy1, pass1, fail1, to1;
    logic [CW-1:0] mc1;
    logic [W-1:0]  ea1, ed1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_store_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(20), .MODE(0)) u_ord (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
        .start(start0), .ign_en(ign_en), .ign_adr(ign_adr),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy0), .pass(pass0), .fail(fail0), .timeout(to0),
        .match_cnt(mc0), .err_adr(ea0), .err_data(ed0)
    );

    mem_store_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(20), .MODE(1)) u_sub (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
        .start(start1), .ign_en(ign_en), .ign_adr(ign_adr),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy1), .pass(pass1), .fail(fail1), .timeout(to1),
        .match_cnt(mc1), .err_adr(ea1), .err_data(ed1)
    );

    typedef struct {
        string         tag;
        int            sel;
        logic          b, p, f, t;
        logic [CW-1:0] mc;
        logic [W-1:0]  ea, ed;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic ex(input string tag, input int sel, input logic b, input logic p,
                      input logic f, input logic t, input logic [CW-1:0] mc,
                      input logic [W-1:0] ea, input logic [W-1:0] ed);
        exp_t e;
        e.tag = tag; e.sel = sel; e.b = b; e.p = p; e.f = f; e.t = t;
        e.mc = mc; e.ea = ea; e.ed = ed;
        sbq.push_back(e);
    endtask

    // one clock edge, then compare everything queued for it
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.sel == 0) begin
                chk({e.tag, ".busy"}, 64'(busy0), 64'(e.b));
                chk({e.tag, ".pass"}, 64'(pass0), 64'(e.p));
                chk({e.tag, ".fail"}, 64'(fail0), 64'(e.f));
                chk({e.tag, ".tmo"},  64'(to0),   64'(e.t));
                chk({e.tag, ".mc"},   64'(mc0),   64'(e.mc));
                chk({e.tag, ".eadr"}, 64'(ea0),   64'(e.ea));
                chk({e.tag, ".edat"}, 64'(ed0),   64'(e.ed));
            end else begin
                chk({e.tag, ".busy"}, 64'(busy1), 64'(e.b));
                chk({e.tag, ".pass"}, 64'(pass1), 64'(e.p));
                chk({e.tag, ".fail"}, 64'(fail1), 64'(e.f));
                chk({e.tag, ".tmo"},  64'(to1),   64'(e.t));
                chk({e.tag, ".mc"},   64'(mc1),   64'(e.mc));
                chk({e.tag, ".eadr"}, 64'(ea1),   64'(e.ea));
                chk({e.tag, ".edat"}, 64'(ed1),   64'(e.ed));
            end
        end
    endtask

    task automatic st(input logic [W-1:0] a, input logic [W-1:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
        exp_we = 1'b1; exp_idx = IW'(idx); exp_adr = a; exp_data = d;
        step();
        exp_we = 1'b0;
    endtask

    task automatic go(input int sel, input int cnt);
        exp_count = CW'(cnt);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        step();
        start0 = 1'b0; start1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=stuck want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; exp_we = 1'b0; exp_idx = '0; exp_adr = '0; exp_data = '0;
        exp_count = '0; start0 = 1'b0; start1 = 1'b0; ign_en = 1'b0; ign_adr = '0;
        memwrite = 1'b0; dataadr = '0; writedata = '0;

        // reset state
        ex("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
        ex("rst1", 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;

        // ordered match, two entries
        wr(0, 80, 7);
        wr(1, 84, 11497);
        ex("o_start", 0, 1, 0, 0, 0, 0, 0, 0); go(0, 2);
        ex("o_st1", 0, 1, 0, 0, 0, 1, 0, 0);   st(80, 7);
        ex("o_st2", 0, 0, 1, 0, 0, 2, 0, 0);   st(84, 11497);
        ex("o_hold", 0, 0, 1, 0, 0, 2, 0, 0);  st(1, 1);

        // scratch filter hides entry 0, so the next store mismatches
        ign_en = 1'b1; ign_adr = 80;
        ex("f_start", 0, 1, 0, 0, 0, 0, 0, 0); go(0, 2);
        ex("f_ign1", 0, 1, 0, 0, 0, 0, 0, 0);  st(80, 99);
        ex("f_ign2", 0, 1, 0, 0, 0, 0, 0, 0);  st(80, 7);
        ex("f_mis", 0, 0, 0, 1, 0, 0, 84, 11497); st(84, 11497);
        ign_en = 1'b0;

        // timeout exactly 20 edges after RUN entry
        go(0, 1);
        for (int i = 1; i <= 19; i++) begin
            if (i == 19) ex("t_last_busy", 0, 1, 0, 0, 0, 0, 0, 0);
            step();
        end
        ex("t_fire", 0, 0, 0, 1, 1, 0, 0, 0); step();

        // final match on the timeout edge: pass wins
        go(0, 1);
        for (int i = 1; i <= 19; i++) step();
        ex("t_passwin", 0, 0, 1, 0, 0, 1, 0, 0); st(80, 7);

        // mismatch on the timeout edge: mismatch wins
        go(0, 1);
        for (int i = 1; i <= 19; i++) step();
        ex("t_miswin", 0, 0, 0, 1, 0, 0, 5, 6); st(5, 6);

        // subsequence mode; this table write must not reach u_ord (in PASS/FAIL)
        wr(0, 84, 11497);
        ex("s_start", 1, 1, 0, 0, 0, 0, 0, 0); go(1, 1);
        ex("s_skip1", 1, 1, 0, 0, 0, 0, 0, 0); st(80, 5);
        ex("s_skip2", 1, 1, 0, 0, 0, 0, 0, 0); st(60, 3);
        ex("s_hit", 1, 0, 1, 0, 0, 1, 0, 0);   st(84, 11497);

        // u_ord table still holds (80,7),(84,11497); reset mid-RUN
        ex("r_start", 0, 1, 0, 0, 0, 0, 0, 0); go(0, 2);
        ex("r_st1", 0, 1, 0, 0, 0, 1, 0, 0);   st(80, 7);
        reset = 1'b1;
        ex("r_rst0", 0, 0, 0, 0, 0, 0, 0, 0);
        ex("r_rst1", 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        // cleared table: entry 0 is (0,0)
        ex("r_clr_start", 0, 1, 0, 0, 0, 0, 0, 0); go(0, 1);
        ex("r_clr_hit", 0, 0, 1, 0, 0, 1, 0, 0);   st(0, 0);
        ex("z_cnt0", 1, 0, 1, 0, 0, 0, 0, 0);      go(1, 0);

        // count saturation and table protection during RUN
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < D; i++) wr(i, W'(100 + 4 * i), W'(3 * i + 1));
        for (int r = 0; r < 2; r++) begin
            ex($sformatf("sat%0d_start", r), 0, 1, 0, 0, 0, 0, 0, 0);
            go(0, 15);
            for (int i = 0; i < D; i++) begin
                if (i == 2 * r + 1) begin
                    exp_we = 1'b1; exp_idx = IW'(5 + r); exp_adr = 32'hdead; exp_data = 32'hbeef;
                end
                if (i == D - 1) ex($sformatf("sat%0d_st%0d", r, i), 0, 0, 1, 0, 0, CW'(i + 1), 0, 0);
                else            ex($sformatf("sat%0d_st%0d", r, i), 0, 1, 0, 0, 0, CW'(i + 1), 0, 0);
                st(W'(100 + 4 * i), W'(3 * i + 1));
                exp_we = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
